// File: rtl/mem_axi_lite_bridge_pkg.sv
// Shared types for the MEM-stage to AXI4-Lite bridge: FSM encoding and AXI response codes.
package mem_axi_lite_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_DONE
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/mem_axi_lite_bridge_vld_hold.sv
// AXI VALID holder: rises the cycle after load, falls only on its own handshake.
// Never consults READY to rise, so VALID can sit high for any number of stalled cycles.
module mem_axi_lite_bridge_vld_hold (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic rdy,
  output logic vld
);

  logic vld_d, vld_q;

  always_comb begin
    vld_d = vld_q;
    if (vld_q && rdy) begin
      vld_d = 1'b0;
    end else if (load) begin
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign vld = vld_q;

endmodule

// File: rtl/mem_axi_lite_bridge.sv
// MEM-stage REQ/FINISH responder running one AXI4-Lite read or write at a time.
// REQ to FINISH is 4 cycles with a zero-wait slave; AXI READY stalls extend the matching state.
module mem_axi_lite_bridge
  import mem_axi_lite_bridge_pkg::*;
#(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter bit RD_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MEM_READ_REQ,
  input  logic [ADDR_W-1:0]   MEM_READ_ADDR,
  output logic [DATA_W-1:0]   MEM_READ_DATA,
  output logic                MEM_READ_FINISH,
  input  logic                MEM_WRITE_REQ,
  input  logic [ADDR_W-1:0]   MEM_WRITE_ADDR,
  input  logic [DATA_W-1:0]   MEM_WRITE_DATA,
  input  logic [DATA_W/8-1:0] MEM_WRITE_STRB,
  output logic                MEM_WRITE_FINISH,
  output logic                MEM_ERR,
  output logic                ARVALID,
  input  logic                ARREADY,
  output logic [ADDR_W-1:0]   ARADDR,
  input  logic                RVALID,
  output logic                RREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic                WVALID,
  input  logic                WREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  input  logic                BVALID,
  output logic                BREADY,
  input  logic [1:0]          BRESP
);

  localparam int STRB_W = DATA_W / 8;

  state_e              state_q, state_d;
  logic                rd_op_q, rd_op_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic ar_load, aw_load;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic pick_rd, pick_wr;

  assign pick_rd = MEM_READ_REQ && (RD_FIRST || !MEM_WRITE_REQ);
  assign pick_wr = MEM_WRITE_REQ && !pick_rd;

  assign RREADY = (state_q == ST_RD_DATA);
  assign BREADY = (state_q == ST_WR_RESP);

  assign ar_hs = ARVALID && ARREADY;
  assign r_hs  = RVALID && RREADY;
  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign b_hs  = BVALID && BREADY;

  always_comb begin
    state_d   = state_q;
    rd_op_d   = rd_op_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;
    araddr_d  = araddr_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    ar_load   = 1'b0;
    aw_load   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_rd) begin
          araddr_d = MEM_READ_ADDR;
          ar_load  = 1'b1;
          rd_op_d  = 1'b1;
          state_d  = ST_RD_ADDR;
        end else if (pick_wr) begin
          awaddr_d = MEM_WRITE_ADDR;
          wdata_d  = MEM_WRITE_DATA;
          wstrb_d  = MEM_WRITE_STRB;
          aw_load  = 1'b1;
          rd_op_d  = 1'b0;
          state_d  = ST_WR_REQ;
        end
      end
      ST_RD_ADDR: begin
        if (ar_hs) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (r_hs) begin
          rdata_d = RDATA;
          err_d   = resp_is_err(RRESP);
          state_d = ST_DONE;
        end
      end
      ST_WR_REQ: begin
        // AW and W may complete in either order; the done flags remember the earlier one.
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (b_hs) begin
          err_d   = resp_is_err(BRESP);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        err_d     = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      rd_op_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
      araddr_q  <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rd_op_q   <= rd_op_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
      araddr_q  <= araddr_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
    end
  end

  mem_axi_lite_bridge_vld_hold u_ar_vld (
    .clk  (clk),
    .rst  (rst),
    .load (ar_load),
    .rdy  (ARREADY),
    .vld  (ARVALID)
  );

  mem_axi_lite_bridge_vld_hold u_aw_vld (
    .clk  (clk),
    .rst  (rst),
    .load (aw_load),
    .rdy  (AWREADY),
    .vld  (AWVALID)
  );

  mem_axi_lite_bridge_vld_hold u_w_vld (
    .clk  (clk),
    .rst  (rst),
    .load (aw_load),
    .rdy  (WREADY),
    .vld  (WVALID)
  );

  assign ARADDR           = araddr_q;
  assign AWADDR           = awaddr_q;
  assign WDATA            = wdata_q;
  assign WSTRB            = wstrb_q;
  assign MEM_READ_DATA    = rdata_q;
  assign MEM_READ_FINISH  = (state_q == ST_DONE) && rd_op_q;
  assign MEM_WRITE_FINISH = (state_q == ST_DONE) && !rd_op_q;
  assign MEM_ERR          = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_mem_axi_lite_bridge.sv
// Directed bench for mem_axi_lite_bridge: MEM-side requester plus a small AXI4-Lite slave,
// all driven from one process at the falling edge.
module tb_mem_axi_lite_bridge;
  import mem_axi_lite_bridge_pkg::*;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;

  logic              clk;
  logic              rst;
  logic              MEM_READ_REQ;
  logic [ADDR_W-1:0] MEM_READ_ADDR;
  logic [DATA_W-1:0] MEM_READ_DATA;
  logic              MEM_READ_FINISH;
  logic              MEM_WRITE_REQ;
  logic [ADDR_W-1:0] MEM_WRITE_ADDR;
  logic [DATA_W-1:0] MEM_WRITE_DATA;
  logic [STRB_W-1:0] MEM_WRITE_STRB;
  logic              MEM_WRITE_FINISH;
  logic              MEM_ERR;
  logic              ARVALID, ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic              RVALID, RREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              AWVALID, AWREADY;
  logic [ADDR_W-1:0] AWADDR;
  logic              WVALID, WREADY;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              BVALID, BREADY;
  logic [1:0]        BRESP;

  int checks;
  int failures;

  // Slave model state: handshakes seen before the coming edge, and what the slave returns.
  logic        ar_pend, r_pend, aw_pend, w_pend, b_pend;
  logic        s_aw_got, s_w_got;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp, s_bresp;
  logic [63:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [7:0]  cap_wstrb;

  mem_axi_lite_bridge #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RD_FIRST (1'b1)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .MEM_READ_REQ     (MEM_READ_REQ),
    .MEM_READ_ADDR    (MEM_READ_ADDR),
    .MEM_READ_DATA    (MEM_READ_DATA),
    .MEM_READ_FINISH  (MEM_READ_FINISH),
    .MEM_WRITE_REQ    (MEM_WRITE_REQ),
    .MEM_WRITE_ADDR   (MEM_WRITE_ADDR),
    .MEM_WRITE_DATA   (MEM_WRITE_DATA),
    .MEM_WRITE_STRB   (MEM_WRITE_STRB),
    .MEM_WRITE_FINISH (MEM_WRITE_FINISH),
    .MEM_ERR          (MEM_ERR),
    .ARVALID          (ARVALID),
    .ARREADY          (ARREADY),
    .ARADDR           (ARADDR),
    .RVALID           (RVALID),
    .RREADY           (RREADY),
    .RDATA            (RDATA),
    .RRESP            (RRESP),
    .AWVALID          (AWVALID),
    .AWREADY          (AWREADY),
    .AWADDR           (AWADDR),
    .WVALID           (WVALID),
    .WREADY           (WREADY),
    .WDATA            (WDATA),
    .WSTRB            (WSTRB),
    .BVALID           (BVALID),
    .BREADY           (BREADY),
    .BRESP            (BRESP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  // One clock: latch handshakes from stable pre-edge values, cross the edge, then update the slave.
  task automatic tick();
    ar_pend = ARVALID && ARREADY;
    if (ar_pend) cap_araddr = ARADDR;
    r_pend  = RVALID && RREADY;
    aw_pend = AWVALID && AWREADY;
    if (aw_pend) cap_awaddr = AWADDR;
    w_pend  = WVALID && WREADY;
    if (w_pend) begin
      cap_wdata = WDATA;
      cap_wstrb = WSTRB;
    end
    b_pend  = BVALID && BREADY;
    @(posedge clk);
    @(negedge clk);
    if (r_pend) RVALID = 1'b0;
    if (ar_pend) begin
      RVALID = 1'b1;
      RDATA  = s_rdata;
      RRESP  = s_rresp;
    end
    if (aw_pend) s_aw_got = 1'b1;
    if (w_pend)  s_w_got  = 1'b1;
    if (b_pend) begin
      BVALID   = 1'b0;
      s_aw_got = 1'b0;
      s_w_got  = 1'b0;
    end else if (s_aw_got && s_w_got) begin
      BVALID = 1'b1;
      BRESP  = s_bresp;
    end
  endtask

  // Waits for the selected FINISH, dropping that REQ in the FINISH cycle; n=-1 on timeout.
  task automatic wait_finish(input bit rd, input int max_cyc, output int n, output logic err);
    n   = -1;
    err = 1'b0;
    for (int i = 1; i <= max_cyc; i++) begin
      tick();
      if (rd ? MEM_READ_FINISH : MEM_WRITE_FINISH) begin
        n   = i;
        err = MEM_ERR;
        if (rd) MEM_READ_REQ = 1'b0;
        else    MEM_WRITE_REQ = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    int          n;
    int          n2;
    int          held;
    int          fin_cnt;
    int          arv_cnt;
    logic        err;
    logic [63:0] a6;

    checks = 0;
    failures = 0;
    rst = 1'b0;
    MEM_READ_REQ = 1'b0;   MEM_READ_ADDR = '0;
    MEM_WRITE_REQ = 1'b0;  MEM_WRITE_ADDR = '0;
    MEM_WRITE_DATA = '0;   MEM_WRITE_STRB = '0;
    ARREADY = 1'b1; AWREADY = 1'b1; WREADY = 1'b1;
    RVALID = 1'b0; RDATA = '0; RRESP = 2'b00;
    BVALID = 1'b0; BRESP = 2'b00;
    s_aw_got = 1'b0; s_w_got = 1'b0;
    s_rdata = '0; s_rresp = RESP_OKAY; s_bresp = RESP_OKAY;
    cap_araddr = '0; cap_awaddr = '0; cap_wdata = '0; cap_wstrb = '0;

    repeat (2) @(negedge clk);
    chk("rst_arvalid", ARVALID, 1'b0);
    chk("rst_awvalid", AWVALID, 1'b0);
    chk("rst_wvalid", WVALID, 1'b0);
    chk("rst_rready", RREADY, 1'b0);
    chk("rst_bready", BREADY, 1'b0);
    chk("rst_finish", {MEM_READ_FINISH, MEM_WRITE_FINISH, MEM_ERR}, 3'b000);
    chk("rst_rdata", MEM_READ_DATA, 64'h0);
    rst = 1'b1;
    tick();

    // T1: zero-wait read
    s_rdata = 64'hDEAD_BEEF_0123_4567;
    MEM_READ_ADDR = 64'h8000_0010;
    MEM_READ_REQ = 1'b1;
    tick();
    chk("t1_arvalid", ARVALID, 1'b1);
    chk("t1_araddr", ARADDR, 64'h8000_0010);
    wait_finish(1'b1, 20, n, err);
    chk("t1_latency", 64'(n + 2), 64'd4);
    chk("t1_rdata", MEM_READ_DATA, 64'hDEAD_BEEF_0123_4567);
    chk("t1_err", err, 1'b0);
    tick();
    chk("t1_one_pulse", MEM_READ_FINISH, 1'b0);
    chk("t1_rdata_hold", MEM_READ_DATA, 64'hDEAD_BEEF_0123_4567);

    // T2: write, AWREADY three cycles ahead of WREADY
    AWREADY = 1'b0; WREADY = 1'b0;
    MEM_WRITE_ADDR = 64'h0000_0000_0000_1000;
    MEM_WRITE_DATA = 64'h55AA;
    MEM_WRITE_STRB = 8'h03;
    MEM_WRITE_REQ = 1'b1;
    tick();
    chk("t2_both_valid", {AWVALID, WVALID, BREADY}, 3'b110);
    chk("t2_wdata", WDATA, 64'h55AA);
    AWREADY = 1'b1;
    tick();
    chk("t2_aw_first", {AWVALID, WVALID, BREADY}, 3'b010);
    AWREADY = 1'b0;
    tick();
    tick();
    chk("t2_w_waiting", {AWVALID, WVALID, BREADY}, 3'b010);
    WREADY = 1'b1;
    tick();
    chk("t2_bready", {AWVALID, WVALID, BREADY}, 3'b001);
    chk("t2_no_early_fin", MEM_WRITE_FINISH, 1'b0);
    AWREADY = 1'b1;
    wait_finish(1'b0, 20, n, err);
    chk("t2_fin_after_b", n, 1);
    chk("t2_awaddr", cap_awaddr, 64'h1000);
    chk("t2_wdata_cap", cap_wdata, 64'h55AA);
    chk("t2_wstrb_cap", cap_wstrb, 8'h03);
    tick();
    chk("t2_one_pulse", {MEM_WRITE_FINISH, BREADY}, 2'b00);
    chk("t2_rdata_untouched", MEM_READ_DATA, 64'hDEAD_BEEF_0123_4567);

    // T3: simultaneous requests, read wins
    s_rdata = 64'h0BAD_F00D_0000_0003;
    MEM_READ_ADDR = 64'h2000;
    MEM_WRITE_ADDR = 64'h3000;
    MEM_WRITE_DATA = 64'h1234;
    MEM_WRITE_STRB = 8'hFF;
    MEM_READ_REQ = 1'b1;
    MEM_WRITE_REQ = 1'b1;
    wait_finish(1'b1, 20, n, err);
    chk("t3_read_first", n, 3);
    chk("t3_no_wr_yet", {MEM_WRITE_FINISH, AWVALID}, 2'b00);
    chk("t3_rdata", MEM_READ_DATA, 64'h0BAD_F00D_0000_0003);
    wait_finish(1'b0, 20, n2, err);
    chk("t3_write_gap", n2, 4);
    chk("t3_awaddr", cap_awaddr, 64'h3000);
    chk("t3_araddr", cap_araddr, 64'h2000);

    // T4: SLVERR on a read, then a clean read
    tick();
    s_rresp = RESP_SLVERR;
    s_rdata = 64'h1111_2222_3333_4444;
    MEM_READ_ADDR = 64'h40;
    MEM_READ_REQ = 1'b1;
    wait_finish(1'b1, 20, n, err);
    chk("t4_err", err, 1'b1);
    chk("t4_rdata", MEM_READ_DATA, 64'h1111_2222_3333_4444);
    tick();
    chk("t4_err_cleared", MEM_ERR, 1'b0);
    s_rresp = RESP_OKAY;
    s_rdata = 64'hCAFE_0000_0000_0004;
    MEM_READ_REQ = 1'b1;
    wait_finish(1'b1, 20, n, err);
    chk("t4_next_ok", err, 1'b0);
    chk("t4_next_rdata", MEM_READ_DATA, 64'hCAFE_0000_0000_0004);
    tick();

    // T5: reset while RVALID is pending in RD_DATA
    s_rdata = 64'h7777_7777_7777_7777;
    MEM_READ_ADDR = 64'h50;
    MEM_READ_REQ = 1'b1;
    tick();
    tick();
    chk("t5_in_rd_data", {RREADY, RVALID}, 2'b11);
    rst = 1'b0;
    #1;
    chk("t5_async_outs", {ARVALID, RREADY, AWVALID, WVALID, BREADY}, 5'b0);
    chk("t5_async_fin", {MEM_READ_FINISH, MEM_WRITE_FINISH, MEM_ERR}, 3'b000);
    chk("t5_async_rdata", MEM_READ_DATA, 64'h0);
    MEM_READ_REQ = 1'b0;
    RVALID = 1'b0;
    BVALID = 1'b0;
    s_aw_got = 1'b0;
    s_w_got = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    fin_cnt = 0;
    arv_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (MEM_READ_FINISH || MEM_WRITE_FINISH) fin_cnt++;
      if (ARVALID) arv_cnt++;
    end
    chk("t5_no_finish", fin_cnt, 0);
    chk("t5_idle", arv_cnt, 0);

    // T6: ARREADY stalled while the MEM address wanders
    a6 = 64'h0000_1234_5678_9AB0;
    s_rdata = 64'h6666_0000_0000_0006;
    ARREADY = 1'b0;
    MEM_READ_ADDR = a6;
    MEM_READ_REQ = 1'b1;
    tick();
    chk("t6_arvalid", ARVALID, 1'b1);
    held = 0;
    for (int i = 0; i < 10; i++) begin
      MEM_READ_ADDR = {$urandom, $urandom};
      tick();
      if (ARVALID && ARADDR == a6) held++;
    end
    chk("t6_held", held, 10);
    ARREADY = 1'b1;
    wait_finish(1'b1, 20, n, err);
    chk("t6_after_hs", n, 2);
    chk("t6_araddr_cap", cap_araddr, a6);
    chk("t6_rdata", MEM_READ_DATA, 64'h6666_0000_0000_0006);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
